// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding and the RISC-V load/store funct3 codes.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_align_check.sv
// Purely combinational misalignment detector for a load/store request.
// Words need addr[1:0] == 0 and halfwords need addr[0] == 0; all other encodings pass.
module dmem_align_check
  import dmem_arb_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_addr_lo,
  output logic       o_misaligned
);

  always_comb begin
    case (i_funct3)
      F3_W:          o_misaligned = |i_addr_lo;
      F3_H, F3_HU:   o_misaligned = i_addr_lo[0];
      F3_B, F3_BU:   o_misaligned = 1'b0;
      default:       o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the pipeline MEM stage (m0)
// and a DMA/debug port (m1); one transaction in flight, IDLE -> ACCESS -> RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DM_ADDRESS-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [2:0]            m0_funct3,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DM_ADDRESS-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [2:0]            m1_funct3,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     mem_rd,
  output logic                  busy
);

  state_e                r_state, w_next;
  logic                  r_last, r_id, r_we, r_err;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata, r_rdata;
  logic [2:0]            r_funct3;

  logic                  w_any, w_sel, w_start, w_mis, w_we, w_resp;
  logic [DM_ADDRESS-1:0] w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [2:0]            w_funct3;

  // On a tie the requester that did not win last time takes the grant.
  assign w_any    = m0_req | m1_req;
  assign w_sel    = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_start  = (r_state == ST_IDLE) & w_any;
  assign w_we     = w_sel ? m1_we     : m0_we;
  assign w_addr   = w_sel ? m1_addr   : m0_addr;
  assign w_wdata  = w_sel ? m1_wdata  : m0_wdata;
  assign w_funct3 = w_sel ? m1_funct3 : m0_funct3;

  dmem_align_check u_align (
    .i_funct3     (w_funct3),
    .i_addr_lo    (w_addr[1:0]),
    .o_misaligned (w_mis)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    a        = '0;
    wd       = '0;
    Funct3   = '0;
    case (r_state)
      ST_IDLE: begin
        // Grant is combinational; gating with rst_n keeps it low while in reset.
        if (w_any && rst_n) begin
          m0_gnt = ~w_sel;
          m1_gnt = w_sel;
          w_next = w_mis ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        MemRead  = ~r_we;
        MemWrite = r_we;
        a        = r_addr;
        wd       = r_wdata;
        Funct3   = r_funct3;
        w_next   = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_funct3 <= '0;
    end else if (w_start) begin
      r_last   <= w_sel;
      r_id     <= w_sel;
      r_we     <= w_we;
      r_err    <= w_mis;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_rdata  <= '0;
      r_funct3 <= w_funct3;
    end else if (r_state == ST_ACCESS && !r_we) begin
      r_rdata  <= mem_rd;
    end
  end

  // Stores and misaligned accesses leave r_rdata at the zero loaded on grant.
  assign w_resp    = (r_state == ST_RESP);
  assign m0_rvalid = w_resp & ~r_id;
  assign m1_rvalid = w_resp & r_id;
  assign m0_rdata  = m0_rvalid ? r_rdata : '0;
  assign m1_rdata  = m1_rvalid ? r_rdata : '0;
  assign m0_err    = m0_rvalid & r_err;
  assign m1_err    = m1_rvalid & r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level model of arbitration, alignment and latency.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [8:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [2:0]  m0_funct3, m1_funct3;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        MemRead, MemWrite, busy;
  logic [8:0]  a;
  logic [31:0] wd, mem_rd;
  logic [2:0]  Funct3;

  int n_tests = 0;
  int n_fail  = 0;
  int model_last;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_funct3(m1_funct3), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .mem_rd(mem_rd), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int access_size(input logic [2:0] f3);
    case (f3)
      3'b010:         return 4;
      3'b001, 3'b101: return 2;
      default:        return 1;
    endcase
  endfunction

  task automatic set_port(input int id, input logic req, input logic we, input logic [8:0] ad,
                          input logic [31:0] wdat, input logic [2:0] f3);
    if (id == 0) begin
      m0_req = req; m0_we = we; m0_addr = ad; m0_wdata = wdat; m0_funct3 = f3;
    end else begin
      m1_req = req; m1_we = we; m1_addr = ad; m1_wdata = wdat; m1_funct3 = f3;
    end
  endtask

  task automatic scramble_payloads();
    m0_we = 1'($urandom); m0_addr = 9'($urandom); m0_wdata = $urandom; m0_funct3 = 3'($urandom);
    m1_we = 1'($urandom); m1_addr = 9'($urandom); m1_wdata = $urandom; m1_funct3 = 3'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".gnt"},    64'({m0_gnt, m1_gnt}), 64'd0);
    check({tag, ".rvalid"}, 64'({m0_rvalid, m1_rvalid}), 64'd0);
    check({tag, ".rdata"},  64'({m0_rdata, m1_rdata}), 64'd0);
    check({tag, ".err"},    64'({m0_err, m1_err}), 64'd0);
    check({tag, ".memctl"}, 64'({MemRead, MemWrite, busy}), 64'd0);
    check({tag, ".memdat"}, 64'({a, wd, Funct3}), 64'd0);
  endtask

  // Called one step after a rising edge with the arbiter idle and requests applied.
  // Predicts the winner, then follows the whole transaction and returns to idle.
  task automatic txn(input string tag);
    int          w, size;
    logic        mis, e_we;
    logic [8:0]  e_addr;
    logic [31:0] e_wd, e_rd;
    logic [2:0]  e_f3;
    w      = (m0_req && m1_req) ? 1 - model_last : (m1_req ? 1 : 0);
    e_we   = (w == 1) ? m1_we : m0_we;
    e_addr = (w == 1) ? m1_addr : m0_addr;
    e_wd   = (w == 1) ? m1_wdata : m0_wdata;
    e_f3   = (w == 1) ? m1_funct3 : m0_funct3;
    size   = access_size(e_f3);
    mis    = (int'(e_addr) % size) != 0;
    e_rd   = (mis || e_we) ? 32'h0 : mem_rd;
    #3;
    check({tag, ".gnt0"},  64'(m0_gnt), 64'(w == 0));
    check({tag, ".gnt1"},  64'(m1_gnt), 64'(w == 1));
    check({tag, ".idle"},  64'({busy, m0_rvalid, m1_rvalid}), 64'd0);
    model_last = w;
    tick();
    m0_req = 1'b0;
    m1_req = 1'b0;
    scramble_payloads();
    if (!mis) begin
      #3;
      check({tag, ".rd"},    64'(MemRead), 64'(!e_we));
      check({tag, ".wr"},    64'(MemWrite), 64'(e_we));
      check({tag, ".a"},     64'(a), 64'(e_addr));
      check({tag, ".wd"},    64'(wd), 64'(e_wd));
      check({tag, ".f3"},    64'(Funct3), 64'(e_f3));
      check({tag, ".acc"},   64'({busy, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt}), 64'b10000);
      tick();
    end
    #3;
    check({tag, ".rv0"},   64'(m0_rvalid), 64'(w == 0));
    check({tag, ".rv1"},   64'(m1_rvalid), 64'(w == 1));
    check({tag, ".rdata"}, 64'((w == 1) ? m1_rdata : m0_rdata), 64'(e_rd));
    check({tag, ".err"},   64'((w == 1) ? m1_err : m0_err), 64'(mis));
    check({tag, ".other"}, 64'((w == 1) ? {m0_rdata, m0_err} : {m1_rdata, m1_err}), 64'd0);
    check({tag, ".nomem"}, 64'({MemRead, MemWrite, busy}), 64'b001);
    tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    mem_rd = 32'h0;
    model_last = 1;
    set_port(0, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
    set_port(1, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
    #2;
    set_port(0, 1'b1, 1'b1, 9'h010, 32'hAAAA5555, 3'b010);
    set_port(1, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
    #1;
    check_outputs_zero("reset0");
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset1");

    // Both request loads continuously after reset: grants alternate, 3 cycles apart.
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    set_port(1, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
    mem_rd = 32'h0BAD_F00D;
    for (int g = 0; g < 4; g++) begin
      #3;
      check("rr.gnt0", 64'(m0_gnt), 64'(g % 2 == 0));
      check("rr.gnt1", 64'(m1_gnt), 64'(g % 2 == 1));
      tick();
      #3;
      check("rr.acc_nogrant", 64'({m0_gnt, m1_gnt}), 64'd0);
      tick();
      #3;
      check("rr.resp_nogrant", 64'({m0_gnt, m1_gnt}), 64'd0);
      check("rr.rvalid", 64'({m0_rvalid, m1_rvalid}), (g % 2 == 0) ? 64'b10 : 64'b01);
      check("rr.rdata", 64'((g % 2 == 0) ? m0_rdata : m1_rdata), 64'h0BAD_F00D);
      tick();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    model_last = 1;
    #3;
    check("rr.drained", 64'({busy, m0_gnt, m1_gnt}), 64'd0);
    tick();

    mem_rd = 32'hDEADBEEF;
    set_port(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    txn("lw_m0");

    set_port(1, 1'b1, 1'b1, 9'h006, 32'h12345678, 3'b010);
    txn("sw_mis_m1");

    set_port(0, 1'b1, 1'b1, 9'h002, 32'h1234ABCD, 3'b001);
    txn("sh_m0");

    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 3));
      scramble_payloads();
      m0_req = r[0];
      m1_req = r[1];
      mem_rd = $urandom;
      if (r == 0) begin
        #3;
        check("rand.idle", 64'({m0_gnt, m1_gnt, busy}), 64'd0);
        tick();
      end else begin
        txn("rand");
      end
    end

    // Reset during the ACCESS of an m1 store: write drops at once, no response follows.
    set_port(0, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
    set_port(1, 1'b1, 1'b1, 9'h008, 32'hCAFE0001, 3'b010);
    #3;
    check("rst.gnt1", 64'(m1_gnt), 64'd1);
    tick();
    m1_req = 1'b0;
    #1;
    check("rst.wr_before", 64'(MemWrite), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst.async");
    m0_req = 1'b1;
    m1_req = 1'b1;
    #1;
    check("rst.gnt_held", 64'({m0_gnt, m1_gnt}), 64'd0);
    tick();
    check("rst.no_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
    rst_n = 1'b1;
    model_last = 1;
    set_port(0, 1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
    set_port(1, 1'b1, 1'b0, 9'h044, 32'h0, 3'b010);
    mem_rd = 32'h600D_0001;
    txn("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have, per requester i in {0,1} (0 = pipeline MEM stage, 1 = DMA/debug), the following ports:
- mi_req  in  1  request valid
- mi_we  in  1  1 = store, 0 = load
- mi_addr  in  DM_ADDRESS  byte address
- mi_wdata  in  DATA_W  store data
- mi_funct3  in  3  RISC-V load/store funct3
- mi_gnt  out  1  request accepted
- mi_rvalid  out  1  response valid
- mi_rdata  out  DATA_W  load data
- mi_err  out  1  misaligned-access error
REQ-006 SHALL have the following memory-side ports:
- MemRead  out  1
- MemWrite  out  1
- a  out  DM_ADDRESS
- wd  out  DATA_W
- Funct3  out  3
- mem_rd  in  DATA_W  read data from data memory
REQ-007 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-009 In IDLE with at least one mi_req high, SHALL assert exactly one mi_gnt combinationally in that cycle, latch the winner's we/addr/wdata/funct3/id at the edge, and go to ACCESS (aligned) or RESP (misaligned).
REQ-010 Arbitration SHALL be round-robin: when both requesters request, the one not granted last wins; the last-grant pointer updates only on a grant.
REQ-011 A single requester SHALL be granted immediately regardless of pointer state.
REQ-012 Requesters SHALL hold req and payload stable until gnt; the arbiter samples the payload only in the gnt cycle; deasserting req before gnt withdraws the request without side effect.
REQ-013 Misalignment SHALL be defined as follows, with all other funct3 values treated as aligned:
- funct3 010 (LW/SW): addr[1:0] != 0
- funct3 001/101 (LH/LHU/SH): addr[0] != 0
REQ-014 In ACCESS, SHALL drive a, wd, Funct3 from the latched values; MemRead = !we, MemWrite = we; capture mem_rd at the end of the cycle; then go to RESP.
REQ-015 Outside ACCESS, MemRead, MemWrite, a, wd and Funct3 SHALL be 0.
REQ-016 In RESP, SHALL assert mi_rvalid for exactly one cycle, to the latched requester only, then go to IDLE.
REQ-017 In the RESP cycle, mi_rdata SHALL be the captured data for loads and 0 for stores.
REQ-018 In the RESP cycle, mi_err SHALL be 1 for misaligned accesses and 0 otherwise.
REQ-019 A misaligned access SHALL skip ACCESS: no MemRead/MemWrite pulse, rdata 0, err 1.
REQ-020 Latency SHALL be gnt-to-rvalid 2 cycles (aligned) or 1 cycle (misaligned); no new gnt SHALL be issued outside IDLE, giving a peak throughput of one access per 3 cycles.
REQ-021 mi_rdata and mi_err SHALL be 0 whenever mi_rvalid is 0.

Reset
REQ-022 While rst_n = 0, SHALL force state IDLE, last-grant pointer to "1 granted last" (so requester 0 wins the first tie), and all latches to 0.
REQ-023 While rst_n = 0, all outputs SHALL be 0.
REQ-024 Reset asserted mid-ACCESS SHALL drop MemWrite immediately; the interrupted transaction produces no rvalid.
REQ-025 A write already committed by the memory before reset SHALL be left as-is.

Structure
REQ-026 Package dmem_arb_pkg SHALL hold the FSM state enum and the funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
REQ-027 Alignment check SHALL be a sub-module dmem_align_check (funct3, addr[1:0] -> misaligned), purely combinational.
REQ-028 The arbiter SHALL be fully registered except gnt and the memory-side drive derived from state.

Verification
REQ-029 m0 LW addr 0x010, mem_rd = 0xDEADBEEF -> m0_gnt in cycle 0, MemRead=1 in cycle 1, m0_rvalid with rdata 0xDEADBEEF and err 0 in cycle 2.
REQ-030 m0 and m1 both request continuously after reset -> grants alternate m0, m1, m0, m1, spaced 3 cycles apart.
REQ-031 m1 SW addr 0x006 -> m1_gnt, no MemWrite pulse, m1_rvalid after 1 cycle with err=1 and rdata 0.
REQ-032 m0 SH addr 0x002, wdata 0x1234ABCD -> single-cycle MemWrite=1 with a=0x002, wd=0x1234ABCD, Funct3=001; m0_rvalid with rdata 0.
REQ-033 rst_n pulled low during the ACCESS of m1 SW -> MemWrite drops asynchronously, no m1_rvalid; after release, the next tie is granted to m0.
